// File: rtl/free_list_if.sv
// Dispatch/retire/recovery bundle between the rename stage and the free list.
interface free_list_if;
  logic [1:0]       haz_nDispatched;
  logic [1:0][5:0]  rob_retireTagOld;
  logic [1:0]       rob_nRetired;
  logic             br_fub_pred_wrong;
  logic [4:0]       bs_recov_fl_tail;
  logic [1:0][5:0]  fl_freeRegs;
  logic [5:0]       fl_availableRegs;
  logic [4:0]       fl_tail;
  logic [4:0]       head;
  logic [31:0][5:0] free;

  modport master (
    output haz_nDispatched, rob_retireTagOld, rob_nRetired,
           br_fub_pred_wrong, bs_recov_fl_tail,
    input  fl_freeRegs, fl_availableRegs, fl_tail, head, free
  );

  modport slave (
    input  haz_nDispatched, rob_retireTagOld, rob_nRetired,
           br_fub_pred_wrong, bs_recov_fl_tail,
    output fl_freeRegs, fl_availableRegs, fl_tail, head, free
  );
endinterface

// File: rtl/free_list.sv
// Circular free list of physical register tags: two allocations and two
// frees per cycle, with head restore from a branch checkpoint on mispredict.
module free_list (
  input  logic       clk,
  input  logic       reset,
  free_list_if.slave fl
);
  localparam int FL_SIZE  = 32;
  localparam int NUM_PHYS = 64;
  localparam int PTR_W    = $clog2(FL_SIZE);
  localparam int TAG_W    = $clog2(NUM_PHYS);
  localparam int CNT_W    = PTR_W + 1;

  logic [FL_SIZE-1:0][TAG_W-1:0] freeMem;
  logic [PTR_W-1:0]              headPtr;
  logic [PTR_W-1:0]              tailPtr;
  logic [CNT_W-1:0]              count;
  logic [PTR_W-1:0]              headNext1;
  logic [PTR_W-1:0]              tailNext1;
  logic [PTR_W-1:0]              recovDist;

  // Pointer arithmetic wraps naturally at the 5-bit width (modulo 32).
  assign headNext1 = headPtr + PTR_W'(1);
  assign tailNext1 = tailPtr + PTR_W'(1);
  // Entries handed out since the checkpoint; zero means nothing to give back.
  assign recovDist = headPtr - fl.bs_recov_fl_tail;

  // Storage, pointers and occupancy; reset wins over every other action.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FL_SIZE; i++) begin
        freeMem[i] <= TAG_W'(FL_SIZE + i);
      end
      headPtr <= '0;
      tailPtr <= '0;
      count   <= CNT_W'(FL_SIZE);
    end else begin
      if (fl.rob_nRetired >= 2'd1) freeMem[tailPtr]   <= fl.rob_retireTagOld[0];
      if (fl.rob_nRetired == 2'd2) freeMem[tailNext1] <= fl.rob_retireTagOld[1];
      tailPtr <= tailPtr + PTR_W'(fl.rob_nRetired);
      if (fl.br_fub_pred_wrong) begin
        // Dispatch is squashed this cycle; wrong-path tags return to the list.
        headPtr <= fl.bs_recov_fl_tail;
        count   <= count + CNT_W'(recovDist) + CNT_W'(fl.rob_nRetired);
      end else begin
        headPtr <= headPtr + PTR_W'(fl.haz_nDispatched);
        count   <= count - CNT_W'(fl.haz_nDispatched) + CNT_W'(fl.rob_nRetired);
      end
    end
  end

  // Allocation candidates are read from pre-write storage, so no same-cycle bypass.
  always_comb begin
    fl.fl_freeRegs[0]   = freeMem[headPtr];
    fl.fl_freeRegs[1]   = freeMem[headNext1];
    fl.fl_availableRegs = count;
    fl.fl_tail          = tailPtr;
    fl.head             = headPtr;
    fl.free             = freeMem;
  end
endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed scenarios plus a randomized run
// against a queue-based model of the free tag pool.
module tb_free_list;
  logic clk = 1'b0;
  logic reset;

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  free_list_if fl ();
  free_list dut (.clk(clk), .reset(reset), .fl(fl));

  int total = 0;
  int bad   = 0;

  // Model: mQ holds free tags in allocation order; hist holds the most recent
  // allocations so a mispredict can hand them back; maxRecov bounds how many
  // of those are still intact in storage.
  int mQ[$];
  int hist[$];
  int mHead, mTail, maxRecov;

  function automatic int minI(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic modelReset();
    mQ.delete();
    for (int i = 0; i < 32; i++) mQ.push_back(32 + i);
    hist.delete();
    mHead = 0;
    mTail = 0;
    maxRecov = 0;
  endtask

  task automatic doReset(input bit junk);
    reset = 1'b1;
    fl.haz_nDispatched     = junk ? 2'd2 : 2'd0;
    fl.rob_nRetired        = junk ? 2'd2 : 2'd0;
    fl.rob_retireTagOld[0] = 6'($urandom_range(0, 63));
    fl.rob_retireTagOld[1] = 6'($urandom_range(0, 63));
    fl.br_fub_pred_wrong   = junk;
    fl.bs_recov_fl_tail    = 5'($urandom_range(0, 31));
    @(posedge clk);
    modelReset();
    @(negedge clk);
    reset = 1'b0;
    fl.haz_nDispatched   = 2'd0;
    fl.rob_nRetired      = 2'd0;
    fl.br_fub_pred_wrong = 1'b0;
  endtask

  task automatic cyc(input int nd, input int nr, input int t0, input int t1,
                     input bit mp, input int ckpt);
    int d;
    fl.haz_nDispatched     = 2'(nd);
    fl.rob_nRetired        = 2'(nr);
    fl.rob_retireTagOld[0] = 6'(t0);
    fl.rob_retireTagOld[1] = 6'(t1);
    fl.br_fub_pred_wrong   = mp;
    fl.bs_recov_fl_tail    = 5'(ckpt);
    @(posedge clk);
    if (mp) begin
      d = (mHead - ckpt + 32) % 32;
      for (int k = 0; k < d; k++) mQ.push_front(hist.pop_back());
      mHead = ckpt;
      maxRecov -= d;
    end else begin
      for (int k = 0; k < nd; k++) begin
        hist.push_back(mQ.pop_front());
        if (hist.size() > 32) void'(hist.pop_front());
      end
      mHead = (mHead + nd) % 32;
      maxRecov = minI(maxRecov + nd, 32);
    end
    if (nr >= 1) mQ.push_back(t0);
    if (nr == 2) mQ.push_back(t1);
    mTail = (mTail + nr) % 32;
    maxRecov = minI(maxRecov, 32 - mQ.size());
    @(negedge clk);
    fl.haz_nDispatched   = 2'd0;
    fl.rob_nRetired      = 2'd0;
    fl.br_fub_pred_wrong = 1'b0;
  endtask

  task automatic test_reset();
    doReset(1'b0);
    total++;
    if (fl.fl_availableRegs !== 6'd32) begin
      bad++; $display("FAIL reset_count got=%0d exp=32", fl.fl_availableRegs);
    end
    total++;
    if (fl.head !== 5'd0 || fl.fl_tail !== 5'd0) begin
      bad++; $display("FAIL reset_ptrs got head=%0d tail=%0d exp 0/0", fl.head, fl.fl_tail);
    end
    total++;
    if (fl.fl_freeRegs[0] !== 6'd32 || fl.fl_freeRegs[1] !== 6'd33) begin
      bad++; $display("FAIL reset_freeRegs got=%0d,%0d exp=32,33", fl.fl_freeRegs[0], fl.fl_freeRegs[1]);
    end
    total++;
    if (fl.free[5] !== 6'd37) begin
      bad++; $display("FAIL reset_free5 got=%0d exp=37", fl.free[5]);
    end
  endtask

  task automatic test_drain();
    for (int k = 0; k < 16; k++) begin
      total++;
      if (fl.fl_freeRegs[0] !== 6'(32 + 2 * k) || fl.fl_freeRegs[1] !== 6'(33 + 2 * k)) begin
        bad++; $display("FAIL drain_tags step=%0d got=%0d,%0d exp=%0d,%0d", k,
                        fl.fl_freeRegs[0], fl.fl_freeRegs[1], 32 + 2 * k, 33 + 2 * k);
      end
      cyc(2, 0, 0, 0, 1'b0, 0);
    end
    total++;
    if (fl.fl_availableRegs !== 6'd0 || fl.head !== 5'd0) begin
      bad++; $display("FAIL drain_end got count=%0d head=%0d exp 0/0", fl.fl_availableRegs, fl.head);
    end
  endtask

  task automatic test_retire_dispatch();
    cyc(0, 2, 5, 9, 1'b0, 0);
    total++;
    if (fl.fl_availableRegs !== 6'd2 || fl.fl_tail !== 5'd2) begin
      bad++; $display("FAIL rd_retire got count=%0d tail=%0d exp 2/2", fl.fl_availableRegs, fl.fl_tail);
    end
    total++;
    if (fl.fl_freeRegs[0] !== 6'd5 || fl.fl_freeRegs[1] !== 6'd9) begin
      bad++; $display("FAIL rd_freeRegs got=%0d,%0d exp=5,9", fl.fl_freeRegs[0], fl.fl_freeRegs[1]);
    end
    cyc(2, 0, 0, 0, 1'b0, 0);
    total++;
    if (fl.fl_availableRegs !== 6'd0 || fl.head !== 5'd2) begin
      bad++; $display("FAIL rd_dispatch got count=%0d head=%0d exp 0/2", fl.fl_availableRegs, fl.head);
    end
  endtask

  task automatic test_wrap();
    doReset(1'b0);
    for (int k = 0; k < 15; k++) cyc(2, 0, 0, 0, 1'b0, 0);
    cyc(1, 0, 0, 0, 1'b0, 0);
    cyc(0, 1, 20, 0, 1'b0, 0);
    total++;
    if (fl.head !== 5'd31 || fl.fl_tail !== 5'd1 || fl.fl_availableRegs !== 6'd2) begin
      bad++; $display("FAIL wrap_setup got head=%0d tail=%0d count=%0d exp 31/1/2",
                      fl.head, fl.fl_tail, fl.fl_availableRegs);
    end
    cyc(0, 2, 7, 8, 1'b0, 0);
    total++;
    if (fl.free[1] !== 6'd7 || fl.free[2] !== 6'd8) begin
      bad++; $display("FAIL wrap_write got free1=%0d free2=%0d exp 7/8", fl.free[1], fl.free[2]);
    end
    total++;
    if (fl.fl_tail !== 5'd3 || fl.fl_availableRegs !== 6'd4) begin
      bad++; $display("FAIL wrap_ptrs got tail=%0d count=%0d exp 3/4", fl.fl_tail, fl.fl_availableRegs);
    end
    total++;
    if (fl.fl_freeRegs[0] !== 6'd63 || fl.fl_freeRegs[1] !== 6'd20) begin
      bad++; $display("FAIL wrap_read got=%0d,%0d exp=63,20", fl.fl_freeRegs[0], fl.fl_freeRegs[1]);
    end
  endtask

  task automatic test_back_to_back();
    int h, t, old0;
    for (int k = 0; k < 3; k++) cyc(0, 2, 10 + k, 13 + k, 1'b0, 0);
    h = mHead;
    t = mTail;
    cyc(1, 2, 11, 12, 1'b0, 0);
    total++;
    if (fl.fl_availableRegs !== 6'd11 || fl.head !== 5'((h + 1) % 32) || fl.fl_tail !== 5'((t + 2) % 32)) begin
      bad++; $display("FAIL b2b_ptrs got count=%0d head=%0d tail=%0d exp 11/%0d/%0d",
                      fl.fl_availableRegs, fl.head, fl.fl_tail, (h + 1) % 32, (t + 2) % 32);
    end
    for (int k = 0; k < 5; k++) cyc(2, 0, 0, 0, 1'b0, 0);
    old0 = mQ[0];
    fl.haz_nDispatched     = 2'd1;
    fl.rob_nRetired        = 2'd2;
    fl.rob_retireTagOld[0] = 6'd40;
    fl.rob_retireTagOld[1] = 6'd41;
    #1;
    total++;
    if (fl.fl_availableRegs !== 6'd1 || fl.fl_freeRegs[0] !== 6'(old0)) begin
      bad++; $display("FAIL nobypass got count=%0d tag=%0d exp 1/%0d", fl.fl_availableRegs, fl.fl_freeRegs[0], old0);
    end
    cyc(1, 2, 40, 41, 1'b0, 0);
    total++;
    if (fl.fl_freeRegs[0] !== 6'd40 || fl.fl_freeRegs[1] !== 6'd41) begin
      bad++; $display("FAIL nextcycle_avail got=%0d,%0d exp=40,41", fl.fl_freeRegs[0], fl.fl_freeRegs[1]);
    end
  endtask

  task automatic test_mispredict();
    doReset(1'b0);
    cyc(2, 0, 0, 0, 1'b0, 0);
    cyc(2, 0, 0, 0, 1'b0, 0);
    cyc(2, 0, 0, 0, 1'b0, 0);
    cyc(2, 0, 0, 0, 1'b0, 0);
    cyc(1, 0, 0, 0, 1'b0, 0);
    total++;
    if (fl.head !== 5'd9 || fl.fl_availableRegs !== 6'd23) begin
      bad++; $display("FAIL mp_setup got head=%0d count=%0d exp 9/23", fl.head, fl.fl_availableRegs);
    end
    cyc(2, 1, 50, 0, 1'b1, 4);
    total++;
    if (fl.head !== 5'd4 || fl.fl_availableRegs !== 6'd29 || fl.fl_tail !== 5'd1) begin
      bad++; $display("FAIL mp_recover got head=%0d count=%0d tail=%0d exp 4/29/1",
                      fl.head, fl.fl_availableRegs, fl.fl_tail);
    end
    total++;
    if (fl.fl_freeRegs[0] !== 6'd36 || fl.fl_freeRegs[1] !== 6'd37) begin
      bad++; $display("FAIL mp_tags got=%0d,%0d exp=36,37", fl.fl_freeRegs[0], fl.fl_freeRegs[1]);
    end
  endtask

  task automatic test_reset_priority();
    cyc(2, 0, 0, 0, 1'b0, 0);
    cyc(0, 2, 3, 4, 1'b0, 0);
    doReset(1'b1);
    total++;
    if (fl.fl_availableRegs !== 6'd32 || fl.head !== 5'd0 || fl.fl_tail !== 5'd0) begin
      bad++; $display("FAIL rstprio_ptrs got count=%0d head=%0d tail=%0d exp 32/0/0",
                      fl.fl_availableRegs, fl.head, fl.fl_tail);
    end
    total++;
    if (fl.free[0] !== 6'd32 || fl.fl_freeRegs[1] !== 6'd33) begin
      bad++; $display("FAIL rstprio_data got free0=%0d fr1=%0d exp 32/33", fl.free[0], fl.fl_freeRegs[1]);
    end
  endtask

  task automatic test_random();
    int cnt, nd, nr, d, ckpt;
    bit mp;
    for (int it = 0; it < 600; it++) begin
      cnt = mQ.size();
      total++;
      if (fl.fl_availableRegs !== 6'(cnt) || fl.head !== 5'(mHead) || fl.fl_tail !== 5'(mTail)) begin
        bad++; $display("FAIL rnd_state it=%0d got count=%0d head=%0d tail=%0d exp %0d/%0d/%0d", it,
                        fl.fl_availableRegs, fl.head, fl.fl_tail, cnt, mHead, mTail);
      end
      if (cnt >= 1) begin
        total++;
        if (fl.fl_freeRegs[0] !== 6'(mQ[0])) begin
          bad++; $display("FAIL rnd_tag0 it=%0d got=%0d exp=%0d", it, fl.fl_freeRegs[0], mQ[0]);
        end
      end
      if (cnt >= 2) begin
        total++;
        if (fl.fl_freeRegs[1] !== 6'(mQ[1])) begin
          bad++; $display("FAIL rnd_tag1 it=%0d got=%0d exp=%0d", it, fl.fl_freeRegs[1], mQ[1]);
        end
      end
      mp = ($urandom_range(0, 7) == 0);
      if (mp) begin
        nr   = $urandom_range(0, minI(2, 32 - cnt));
        d    = $urandom_range(0, minI(31, minI(maxRecov, 32 - cnt - nr)));
        ckpt = (mHead - d + 32) % 32;
        nd   = $urandom_range(0, 2);
      end else begin
        nd   = $urandom_range(0, minI(2, cnt));
        nr   = $urandom_range(0, minI(2, 32 - cnt + nd));
        ckpt = $urandom_range(0, 31);
      end
      cyc(nd, nr, $urandom_range(0, 63), $urandom_range(0, 63), mp, ckpt);
    end
  endtask

  // Directed scenarios in order, then the randomized run and the summary.
  initial begin
    reset = 1'b1;
    fl.haz_nDispatched   = 2'd0;
    fl.rob_nRetired      = 2'd0;
    fl.rob_retireTagOld  = '0;
    fl.br_fub_pred_wrong = 1'b0;
    fl.bs_recov_fl_tail  = 5'd0;
    @(negedge clk);
    test_reset();
    test_drain();
    test_retire_dispatch();
    test_wrap();
    test_back_to_back();
    test_mispredict();
    test_reset_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
